// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the inter-stage pipeline buffers.
package pipe_pkg;

    // Stall-vector bit index of each pipeline stage
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam int STALL_W_DEFAULT = 6;

    localparam int PAYLOAD_W_ID_EX  = 104;
    localparam int PAYLOAD_W_EX_MEM = 104;
    localparam int PAYLOAD_W_MEM_WB = 104;
    localparam int CARRY_W_ID_EX    = 66;
    localparam int CARRY_W_EX_MEM   = 66;
    localparam int CARRY_W_MEM_WB   = 66;

    // A bubble is a slot whose valid bit is clear and whose payload is all zero
    localparam logic BUBBLE_VALID = 1'b0;

    typedef enum logic [2:0] {
        ACT_RESET   = 3'd0,
        ACT_FLUSH   = 3'd1,
        ACT_BUBBLE  = 3'd2,
        ACT_ADVANCE = 3'd3,
        ACT_HOLD    = 3'd4
    } action_e;

    function automatic action_e decode_action(
        input logic reset,
        input logic flush,
        input logic up,
        input logic dn
    );
        if (reset)
            return ACT_RESET;
        else if (flush)
            return ACT_FLUSH;
        else if (!up)
            return ACT_ADVANCE;
        else if (!dn)
            return ACT_BUBBLE;
        else
            return ACT_HOLD;
    endfunction

endpackage

// File: rtl/pipe_stage_buffer_sat_counter.sv
// Saturating up-counter with synchronous clear; tracks consecutive stall cycles.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset || clr)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Generic inter-stage pipeline register with flush, bubble insertion and stall monitor.
// Define PIPE_STAGE_STATS_EN to build the bubble/flush statistics counters.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int STALL_W   = STALL_W_DEFAULT,
    parameter int STAGE     = STG_EX,
    parameter int PAYLOAD_W = PAYLOAD_W_EX_MEM,
    parameter int CARRY_W   = CARRY_W_EX_MEM,
    parameter int HOLD_W    = 4,
    parameter int MAX_HOLD  = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [CARRY_W-1:0]   in_carry,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CARRY_W-1:0]   out_carry,
    output logic [HOLD_W-1:0]    hold_count,
    output logic                 hold_timeout,
    output logic [31:0]          stat_bubbles,
    output logic [31:0]          stat_flushes
);

    if (STAGE >= STALL_W || STAGE < 0) begin : g_bad_stage
        $fatal(1, "pipe_stage_buffer: STAGE must index the stall vector");
    end
    if (PAYLOAD_W < 1) begin : g_bad_payload
        $fatal(1, "pipe_stage_buffer: PAYLOAD_W must be at least 1");
    end
    if (CARRY_W < 1) begin : g_bad_carry
        $fatal(1, "pipe_stage_buffer: CARRY_W must be at least 1");
    end
    if (MAX_HOLD < 0 || MAX_HOLD > (2 ** HOLD_W) - 1) begin : g_bad_hold
        $fatal(1, "pipe_stage_buffer: MAX_HOLD does not fit in HOLD_W bits");
    end

    logic    up;
    logic    dn;
    action_e act;
    logic    hold_clr;
    logic    unused_stall;

    assign up = stall[STAGE];

    // The last stage has no downstream consumer, so a stall there always drains into a bubble
    if (STAGE == STALL_W - 1) begin : g_dn_last
        assign dn = 1'b0;
    end else begin : g_dn_next
        assign dn = stall[STAGE+1];
    end

    assign unused_stall = ^stall;

    assign act = decode_action(reset, flush, up, dn);

    always_ff @(posedge clock) begin
        case (act)
            ACT_RESET, ACT_FLUSH: begin
                out_valid   <= 1'b0;
                out_payload <= '0;
                out_carry   <= '0;
            end
            ACT_BUBBLE: begin
                out_valid   <= BUBBLE_VALID;
                out_payload <= '0;
                out_carry   <= in_carry;
            end
            ACT_ADVANCE: begin
                out_valid   <= in_valid;
                out_payload <= in_payload;
                out_carry   <= '0;
            end
            ACT_HOLD: begin
                out_carry   <= in_carry;
            end
            default: begin
                out_valid   <= 1'b0;
                out_payload <= '0;
                out_carry   <= '0;
            end
        endcase
    end

    assign hold_clr = (act == ACT_FLUSH) || (act == ACT_ADVANCE);

    sat_counter #(
        .W(HOLD_W)
    ) u_hold (
        .clock (clock),
        .reset (reset),
        .clr   (hold_clr),
        .inc   (up),
        .count (hold_count)
    );

    if (MAX_HOLD == 0) begin : g_no_timeout
        assign hold_timeout = 1'b0;
    end else begin : g_timeout
        assign hold_timeout = (hold_count >= HOLD_W'(MAX_HOLD));
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] bubbles_q;
    logic [31:0] flushes_q;

    always_ff @(posedge clock) begin
        if (act == ACT_RESET) begin
            bubbles_q <= '0;
            flushes_q <= '0;
        end else begin
            if (act == ACT_BUBBLE)
                bubbles_q <= bubbles_q + 32'd1;
            if (act == ACT_FLUSH)
                flushes_q <= flushes_q + 32'd1;
        end
    end

    assign stat_bubbles = bubbles_q;
    assign stat_flushes = flushes_q;
`else
    assign stat_bubbles = 32'd0;
    assign stat_flushes = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed, table-driven bench for pipe_stage_buffer (EX/MEM default, saturation variant, last-stage variant).
module tb_pipe_stage_buffer;
    import pipe_pkg::*;

`ifdef PIPE_STAGE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic [5:0]    stall;
    logic          flush;
    logic          in_valid;
    logic [103:0]  in_payload;
    logic [65:0]   in_carry;

    logic          a_valid;
    logic [103:0]  a_payload;
    logic [65:0]   a_carry;
    logic [3:0]    a_hold;
    logic          a_to;
    logic [31:0]   a_bub;
    logic [31:0]   a_fl;

    logic          b_valid;
    logic [103:0]  b_payload;
    logic [65:0]   b_carry;
    logic [1:0]    b_hold;
    logic          b_to;
    logic [31:0]   b_bub;
    logic [31:0]   b_fl;

    logic          c_valid;
    logic [7:0]    c_payload;
    logic [3:0]    c_carry;
    logic [3:0]    c_hold;
    logic          c_to;
    logic [31:0]   c_bub;
    logic [31:0]   c_fl;

    int checks = 0;
    int errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    pipe_stage_buffer #(
        .STALL_W(6), .STAGE(STG_EX), .PAYLOAD_W(104), .CARRY_W(66), .HOLD_W(4), .MAX_HOLD(0)
    ) dut_a (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload), .in_carry(in_carry),
        .out_valid(a_valid), .out_payload(a_payload), .out_carry(a_carry),
        .hold_count(a_hold), .hold_timeout(a_to),
        .stat_bubbles(a_bub), .stat_flushes(a_fl)
    );

    pipe_stage_buffer #(
        .STALL_W(6), .STAGE(STG_EX), .PAYLOAD_W(104), .CARRY_W(66), .HOLD_W(2), .MAX_HOLD(3)
    ) dut_b (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload), .in_carry(in_carry),
        .out_valid(b_valid), .out_payload(b_payload), .out_carry(b_carry),
        .hold_count(b_hold), .hold_timeout(b_to),
        .stat_bubbles(b_bub), .stat_flushes(b_fl)
    );

    pipe_stage_buffer #(
        .STALL_W(6), .STAGE(STG_WB), .PAYLOAD_W(8), .CARRY_W(4), .HOLD_W(4), .MAX_HOLD(0)
    ) dut_c (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload[7:0]), .in_carry(in_carry[3:0]),
        .out_valid(c_valid), .out_payload(c_payload), .out_carry(c_carry),
        .hold_count(c_hold), .hold_timeout(c_to),
        .stat_bubbles(c_bub), .stat_flushes(c_fl)
    );

    typedef struct {
        logic         rst;
        logic [5:0]   stl;
        logic         fl;
        logic         v;
        logic [103:0] p;
        logic [65:0]  c;
        logic         e_v;
        logic [103:0] e_p;
        logic [65:0]  e_c;
        logic [3:0]   e_h;
        logic [1:0]   e_hb;
        logic         e_tb;
        logic [31:0]  e_bub;
        logic [31:0]  e_fl;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic rst, input logic [5:0] stl, input logic fl, input logic v,
        input logic [103:0] p, input logic [65:0] c,
        input logic e_v, input logic [103:0] e_p, input logic [65:0] e_c,
        input logic [3:0] e_h, input logic [1:0] e_hb, input logic e_tb,
        input logic [31:0] e_bub, input logic [31:0] e_fl
    );
        vec_t r;
        r.rst = rst; r.stl = stl; r.fl = fl; r.v = v; r.p = p; r.c = c;
        r.e_v = e_v; r.e_p = e_p; r.e_c = e_c; r.e_h = e_h; r.e_hb = e_hb;
        r.e_tb = e_tb; r.e_bub = e_bub; r.e_fl = e_fl;
        return r;
    endfunction

    task automatic chk(input string nm, input int row, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        //            rst stall      fl v  payload    carry              | v  payload    carry              hA hB tB bub fl
        vecs[0]  = mk(1, 6'b000000, 0, 0, 104'h0,    66'h0,             0, 104'h0,    66'h0,             0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 6'b000000, 0, 1, 104'hABCD, 66'h123,           1, 104'hABCD, 66'h0,             0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 6'b001000, 0, 1, 104'hFFFF, 66'h3_0000_0001,   0, 104'h0,    66'h3_0000_0001,   1, 1, 0, 1, 0);
        vecs[3]  = mk(0, 6'b000000, 0, 1, 104'h55,   66'h0,             1, 104'h55,   66'h0,             0, 0, 0, 1, 0);
        vecs[4]  = mk(0, 6'b011000, 0, 1, 104'h99,   66'h11,            1, 104'h55,   66'h11,            1, 1, 0, 1, 0);
        vecs[5]  = mk(0, 6'b011000, 0, 1, 104'h99,   66'h22,            1, 104'h55,   66'h22,            2, 2, 0, 1, 0);
        vecs[6]  = mk(0, 6'b011000, 0, 1, 104'h99,   66'h33,            1, 104'h55,   66'h33,            3, 3, 1, 1, 0);
        vecs[7]  = mk(0, 6'b011000, 0, 1, 104'h99,   66'h44,            1, 104'h55,   66'h44,            4, 3, 1, 1, 0);
        vecs[8]  = mk(0, 6'b011000, 0, 1, 104'h99,   66'h55,            1, 104'h55,   66'h55,            5, 3, 1, 1, 0);
        vecs[9]  = mk(0, 6'b011000, 0, 1, 104'h99,   66'h66,            1, 104'h55,   66'h66,            6, 3, 1, 1, 0);
        vecs[10] = mk(0, 6'b000000, 0, 0, 104'h77,   66'h7,             0, 104'h77,   66'h0,             0, 0, 0, 1, 0);
        vecs[11] = mk(0, 6'b000000, 0, 1, 104'h88,   66'h7,             1, 104'h88,   66'h0,             0, 0, 0, 1, 0);
        vecs[12] = mk(0, 6'b011000, 1, 1, 104'hAA,   66'h5,             0, 104'h0,    66'h0,             0, 0, 0, 1, 1);
        vecs[13] = mk(0, 6'b011000, 0, 1, 104'hBB,   66'h6,             0, 104'h0,    66'h6,             1, 1, 0, 1, 1);
        vecs[14] = mk(0, 6'b011000, 0, 1, 104'hBB,   66'h7,             0, 104'h0,    66'h7,             2, 2, 0, 1, 1);
        vecs[15] = mk(1, 6'b011000, 0, 1, 104'hBB,   66'h8,             0, 104'h0,    66'h0,             0, 0, 0, 0, 0);
        vecs[16] = mk(0, 6'b000000, 0, 1, 104'hCAFE, 66'h9,             1, 104'hCAFE, 66'h0,             0, 0, 0, 0, 0);

        reset = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b0; in_payload = '0; in_carry = '0;

        for (int i = 0; i < NVEC; i++) begin
            reset      = vecs[i].rst;
            stall      = vecs[i].stl;
            flush      = vecs[i].fl;
            in_valid   = vecs[i].v;
            in_payload = vecs[i].p;
            in_carry   = vecs[i].c;
            step();
            chk("out_valid",    i, 128'(a_valid),   128'(vecs[i].e_v));
            chk("out_payload",  i, 128'(a_payload), 128'(vecs[i].e_p));
            chk("out_carry",    i, 128'(a_carry),   128'(vecs[i].e_c));
            chk("hold_count",   i, 128'(a_hold),    128'(vecs[i].e_h));
            chk("hold_timeout_disabled", i, 128'(a_to), 128'(1'b0));
            chk("sat_hold_count",   i, 128'(b_hold), 128'(vecs[i].e_hb));
            chk("sat_hold_timeout", i, 128'(b_to),   128'(vecs[i].e_tb));
            chk("stat_bubbles", i, 128'(a_bub), STATS_ON ? 128'(vecs[i].e_bub) : 128'(0));
            chk("stat_flushes", i, 128'(a_fl),  STATS_ON ? 128'(vecs[i].e_fl)  : 128'(0));
        end

        // Last stage in the vector: no downstream stall bit, so any stall bubbles
        stall = 6'b000000; flush = 1'b0; in_valid = 1'b1; in_payload = 104'h5A; in_carry = 66'h9;
        step();
        chk("last_adv_valid",   100, 128'(c_valid),   128'(1'b1));
        chk("last_adv_payload", 100, 128'(c_payload), 128'(8'h5A));
        chk("last_adv_carry",   100, 128'(c_carry),   128'(4'h0));

        stall = 6'b100000; in_payload = 104'h3C; in_carry = 66'hC;
        step();
        chk("last_bub_valid",   101, 128'(c_valid),   128'(1'b0));
        chk("last_bub_payload", 101, 128'(c_payload), 128'(8'h00));
        chk("last_bub_carry",   101, 128'(c_carry),   128'(4'hC));
        chk("last_bub_hold",    101, 128'(c_hold),    128'(4'd1));
        chk("mid_adv_payload",  101, 128'(a_payload), 128'(104'h3C));

        in_carry = 66'hD;
        step();
        chk("last_bub2_valid",  102, 128'(c_valid),   128'(1'b0));
        chk("last_bub2_carry",  102, 128'(c_carry),   128'(4'hD));
        chk("last_bub2_hold",   102, 128'(c_hold),    128'(4'd2));

        // Flush with the last stage stalled clears it too
        flush = 1'b1;
        step();
        chk("last_flush_hold",  103, 128'(c_hold),    128'(4'd0));
        chk("last_flush_carry", 103, 128'(c_carry),   128'(4'h0));
        chk("mid_flush_valid",  103, 128'(a_valid),   128'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
